falafel_lsu: RTL

Load/store unit that serves header requests from falafel_core and turns each header operation into word accesses on a single-port memory bus. It accepts one request at a time using the header_req_t/header_rsp_t handshake. It implements LOCK, UNLOCK, LOAD, EDIT_NEXT_ADDR and EDIT_SIZE_AND_NEXT_ADDR. It sits between the allocator core and the shared heap memory; the lock word lives in that memory.

---
 rtl/falafel_lsu.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/falafel_lsu.sv
// falafel_lsu: turns falafel_core header requests into single-port word accesses on the heap memory.
// Optional lock-retry backoff is built when FALAFEL_LSU_BACKOFF_EN is defined.

package falafel_pkg;
    localparam int DATA_W = 32;

    typedef logic [2:0] lsu_op_t;
    localparam lsu_op_t LSU_LOCK                    = 3'd0;
    localparam lsu_op_t LSU_UNLOCK                  = 3'd1;
    localparam lsu_op_t LSU_LOAD                    = 3'd2;
    localparam lsu_op_t LSU_EDIT_NEXT_ADDR          = 3'd3;
    localparam lsu_op_t LSU_EDIT_SIZE_AND_NEXT_ADDR = 3'd4;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] size;
        logic [DATA_W-1:0] next_addr;
    } header_t;

    typedef struct packed {
        header_t header;
        lsu_op_t lsu_op;
        logic    val;
    } header_req_t;

    typedef struct packed {
        header_t header;
        logic    val;
    } header_rsp_t;
endpackage

module falafel_lsu #(
    parameter int                DATA_W         = falafel_pkg::DATA_W,
    parameter int                WORD_BYTES     = DATA_W / 8,
    parameter logic [DATA_W-1:0] LOCK_ADDR      = '0,
    parameter int                BACKOFF_CYCLES = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  falafel_pkg::header_req_t req_from_core_i,
    output logic                     lsu_ready_o,
    output falafel_pkg::header_rsp_t rsp_to_core_o,
    output logic                     mem_req_o,
    input  logic                     mem_gnt_i,
    output logic                     mem_we_o,
    output logic [DATA_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    input  logic                     mem_rvalid_i,
    input  logic [DATA_W-1:0]        mem_rdata_i,
    output logic                     mem_lock_o
);
    import falafel_pkg::*;

    // Header fields are sized by the package, so the two widths must agree.
    if (DATA_W != falafel_pkg::DATA_W || BACKOFF_CYCLES < 1) begin : g_bad_params
        $error("falafel_lsu: DATA_W must match falafel_pkg::DATA_W and BACKOFF_CYCLES must be >= 1");
    end

    typedef enum logic [3:0] {
        IDLE, LOCK_RD, LOCK_WR, LOCK_WAIT, LD_SIZE, LD_NEXT,
        WR_SIZE, WR_NEXT, UNLOCK_WR, RESP
    } state_t;

    state_t            r_state;
    logic              r_wait;      // 0: request phase, 1: waiting for rvalid
    header_t           r_hdr;
    logic              r_rsp_val;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_lock;

`ifdef FALAFEL_LSU_BACKOFF_EN
    localparam int BO_W = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
    logic [BO_W-1:0] r_backoff;
`endif

    logic [DATA_W-1:0] w_req_next_ptr;
    logic [DATA_W-1:0] w_hdr_next_ptr;

    assign w_req_next_ptr = req_from_core_i.header.addr + DATA_W'(WORD_BYTES);
    assign w_hdr_next_ptr = r_hdr.addr + DATA_W'(WORD_BYTES);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_wait      <= 1'b0;
            r_hdr       <= '0;
            r_rsp_val   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_lock  <= 1'b0;
`ifdef FALAFEL_LSU_BACKOFF_EN
            r_backoff   <= '0;
`endif
        end else begin
            r_rsp_val <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_from_core_i.val) begin
                        r_hdr  <= req_from_core_i.header;
                        r_wait <= 1'b0;
                        case (req_from_core_i.lsu_op)
                            LSU_LOCK: begin
                                r_state    <= LOCK_RD;
                                r_mem_req  <= 1'b1;
                                r_mem_we   <= 1'b0;
                                r_mem_addr <= LOCK_ADDR;
                                r_mem_lock <= 1'b1;
                            end
                            LSU_UNLOCK: begin
                                r_state     <= UNLOCK_WR;
                                r_mem_req   <= 1'b1;
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= LOCK_ADDR;
                                r_mem_wdata <= '0;
                            end
                            LSU_LOAD: begin
                                r_state    <= LD_SIZE;
                                r_mem_req  <= 1'b1;
                                r_mem_we   <= 1'b0;
                                r_mem_addr <= req_from_core_i.header.addr;
                            end
                            LSU_EDIT_NEXT_ADDR: begin
                                r_state     <= WR_NEXT;
                                r_mem_req   <= 1'b1;
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= w_req_next_ptr;
                                r_mem_wdata <= req_from_core_i.header.next_addr;
                            end
                            LSU_EDIT_SIZE_AND_NEXT_ADDR: begin
                                r_state     <= WR_SIZE;
                                r_mem_req   <= 1'b1;
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= req_from_core_i.header.addr;
                                r_mem_wdata <= req_from_core_i.header.size;
                            end
                            default: begin
                                r_state   <= RESP;
                                r_rsp_val <= 1'b1;
                            end
                        endcase
                    end
                end

                RESP: r_state <= IDLE;

`ifdef FALAFEL_LSU_BACKOFF_EN
                LOCK_WAIT: begin
                    if (r_backoff == '0) begin
                        r_state    <= LOCK_RD;
                        r_mem_req  <= 1'b1;
                        r_mem_lock <= 1'b1;
                    end else begin
                        r_backoff <= r_backoff - 1'b1;
                    end
                end
`endif

                default: begin
                    // Every remaining state is a single memory access.
                    if (!r_wait) begin
                        if (mem_gnt_i) begin
                            r_mem_req <= 1'b0;
                            r_wait    <= 1'b1;
                        end
                    end else if (mem_rvalid_i) begin
                        r_wait <= 1'b0;
                        case (r_state)
                            LOCK_RD: begin
                                if (mem_rdata_i == '0) begin
                                    r_state     <= LOCK_WR;
                                    r_mem_req   <= 1'b1;
                                    r_mem_we    <= 1'b1;
                                    r_mem_wdata <= DATA_W'(1);
                                end else begin
`ifdef FALAFEL_LSU_BACKOFF_EN
                                    r_state    <= LOCK_WAIT;
                                    r_mem_lock <= 1'b0;
                                    r_backoff  <= BO_W'(BACKOFF_CYCLES - 1);
`else
                                    r_mem_req  <= 1'b1;
`endif
                                end
                            end
                            LD_SIZE: begin
                                r_hdr.size <= mem_rdata_i;
                                r_state    <= LD_NEXT;
                                r_mem_req  <= 1'b1;
                                r_mem_addr <= w_hdr_next_ptr;
                            end
                            LD_NEXT: begin
                                r_hdr.next_addr <= mem_rdata_i;
                                r_state         <= RESP;
                                r_rsp_val       <= 1'b1;
                            end
                            WR_SIZE: begin
                                r_state     <= WR_NEXT;
                                r_mem_req   <= 1'b1;
                                r_mem_addr  <= w_hdr_next_ptr;
                                r_mem_wdata <= r_hdr.next_addr;
                            end
                            LOCK_WR: begin
                                r_mem_lock <= 1'b0;
                                r_state    <= RESP;
                                r_rsp_val  <= 1'b1;
                            end
                            default: begin
                                r_state   <= RESP;
                                r_rsp_val <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign lsu_ready_o          = (r_state == IDLE) && !rst_i;
    assign rsp_to_core_o.header = r_hdr;
    assign rsp_to_core_o.val    = r_rsp_val;
    assign mem_req_o            = r_mem_req;
    assign mem_we_o             = r_mem_we;
    assign mem_addr_o           = r_mem_addr;
    assign mem_wdata_o          = r_mem_wdata;
    assign mem_lock_o           = r_mem_lock;

endmodule
